// File: rtl/dp_ram_arb_pkg.sv
// Shared constants and helpers for the dual-port RAM port arbiter.
package dp_ram_arb_pkg;

  localparam logic [2:0] STARVE_LIMIT = 3'd4;
  localparam int         SLICE_MAX    = 256;

  function automatic int idw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Callers size-cast both the argument and the result to their own widths.
  function automatic logic [SLICE_MAX-1:0] slice_bits(input logic [SLICE_MAX-1:0] vec,
                                                      input int idx, input int w);
    return vec >> (idx * w);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps at N.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o
);

  // First asserted request at or after the pointer wins.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] pos;
    logic           found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (IDW+1)'(k);
      sum = (sum >= (IDW+1)'(N)) ? (sum - (IDW+1)'(N)) : sum;
      pos = sum[IDW-1:0];
      if (!found && req_i[pos]) begin
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/dp_ram_port_arbiter.sv
// Shares RAM port A among N requesters, sequences a write-only client onto
// port B, resolves same-address collisions and returns reads one cycle later.
module dp_ram_port_arbiter
  import dp_ram_arb_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int AW  = 6,
  parameter  int DW  = 16,
  localparam int IDW = idw_of(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    req_we,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_wdata,
  output logic [N-1:0]    gnt,
  output logic            rvalid,
  output logic [IDW-1:0]  rid,
  output logic [DW-1:0]   rdata,
  input  logic            bwr_valid,
  input  logic [AW-1:0]   bwr_addr,
  input  logic [DW-1:0]   bwr_data,
  output logic            bwr_ready,
  output logic            ram_ena,
  output logic            ram_wea,
  output logic [AW-1:0]   ram_addra,
  output logic [DW-1:0]   ram_dia,
  input  logic [DW-1:0]   ram_doa,
  output logic            ram_enb,
  output logic [AW-1:0]   ram_addrb,
  output logic [DW-1:0]   ram_dib
);

  logic [AW-1:0]  addr_s [N];
  logic [DW-1:0]  wdata_s [N];
  logic [N-1:0]   req_m_s;
  logic [N-1:0]   gnt_s;
  logic [IDW-1:0] win_s;
  logic           any_gnt_s;
  logic           starve_s;
  logic           same_s;
  logic           b_block_s;
  logic           rd_s;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           rvalid_q, rvalid_d;
  logic [IDW-1:0] rid_q, rid_d;
  logic           byp_q, byp_d;
  logic [DW-1:0]  byp_data_q, byp_data_d;
  logic [2:0]     starve_q, starve_d;

  // Unpack requester fields and mask requests that would keep starving port B.
  always_comb begin
    starve_s = bwr_valid && (starve_q >= STARVE_LIMIT);
    for (int i = 0; i < N; i++) begin
      addr_s[i]  = AW'(slice_bits(SLICE_MAX'(req_addr), i, AW));
      wdata_s[i] = DW'(slice_bits(SLICE_MAX'(req_wdata), i, DW));
      req_m_s[i] = req[i] && !rst && !(starve_s && (addr_s[i] == bwr_addr));
    end
  end

  rr_arbiter #(.N(N), .IDW(IDW)) u_rr (
    .req_i (req_m_s),
    .ptr_i (ptr_q),
    .gnt_o (gnt_s),
    .idx_o (win_s)
  );

  // Port-A mux and port-B collision resolution.
  always_comb begin
    any_gnt_s = |gnt_s;
    if (any_gnt_s) begin
      ram_wea   = req_we[win_s];
      ram_addra = addr_s[win_s];
      ram_dia   = wdata_s[win_s];
    end else begin
      ram_wea   = 1'b0;
      ram_addra = '0;
      ram_dia   = '0;
    end
    same_s    = any_gnt_s && bwr_valid && (ram_addra == bwr_addr);
    b_block_s = same_s && ram_wea;
    rd_s      = any_gnt_s && !ram_wea;
    bwr_ready = bwr_valid && !rst && !b_block_s;
  end

  assign gnt       = gnt_s;
  assign ram_ena   = any_gnt_s;
  assign ram_enb   = bwr_ready;
  assign ram_addrb = bwr_addr;
  assign ram_dib   = bwr_data;

  // A read that loses the same-address race to port B sees B's data instead.
  assign rvalid = rvalid_q && !rst;
  assign rid    = rst ? '0 : rid_q;
  assign rdata  = rvalid ? (byp_q ? byp_data_q : ram_doa) : '0;

  // Next-state for pointer, read response, bypass and starvation counter.
  always_comb begin
    if (any_gnt_s) begin
      ptr_d = (win_s == IDW'(N-1)) ? '0 : (win_s + IDW'(1));
    end else begin
      ptr_d = ptr_q;
    end
    rvalid_d   = rd_s;
    rid_d      = rd_s ? win_s : rid_q;
    byp_d      = rd_s && same_s;
    byp_data_d = (rd_s && same_s) ? bwr_data : byp_data_q;
    if (b_block_s && (starve_q != 3'd7)) begin
      starve_d = starve_q + 3'd1;
    end else if (bwr_ready) begin
      starve_d = 3'd0;
    end else begin
      starve_d = starve_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      rvalid_q   <= 1'b0;
      rid_q      <= '0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      starve_q   <= 3'd0;
    end else begin
      ptr_q      <= ptr_d;
      rvalid_q   <= rvalid_d;
      rid_q      <= rid_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
      starve_q   <= starve_d;
    end
  end

endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
// Bench for dp_ram_port_arbiter: a RAM model on both ports plus a
// transaction-level reference model checked every cycle.
module tb_dp_ram_port_arbiter;

  localparam int N   = 4;
  localparam int AW  = 6;
  localparam int DW  = 16;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic            rvalid;
  logic [IDW-1:0]  rid;
  logic [DW-1:0]   rdata;
  logic            bwr_valid;
  logic [AW-1:0]   bwr_addr;
  logic [DW-1:0]   bwr_data;
  logic            bwr_ready;
  logic            ram_ena, ram_wea, ram_enb;
  logic [AW-1:0]   ram_addra, ram_addrb;
  logic [DW-1:0]   ram_dia, ram_dib, ram_doa;

  logic            preload;
  logic [DW-1:0]   ram_mem [64];

  always #5 clk = ~clk;

  dp_ram_port_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rid(rid), .rdata(rdata),
    .bwr_valid(bwr_valid), .bwr_addr(bwr_addr), .bwr_data(bwr_data),
    .bwr_ready(bwr_ready), .ram_ena(ram_ena), .ram_wea(ram_wea),
    .ram_addra(ram_addra), .ram_dia(ram_dia), .ram_doa(ram_doa),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dib(ram_dib)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 257) ^ 16'hA5C3;
  endfunction

  // Read-first 1RW+1W RAM with registered port-A output.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= init_val(i);
    end else begin
      if (ram_ena) begin
        ram_doa <= ram_mem[ram_addra];
        if (ram_wea) ram_mem[ram_addra] <= ram_dia;
      end
      if (ram_enb) ram_mem[ram_addrb] <= ram_dib;
    end
  end

  // Reference model state
  logic [DW-1:0] exp_mem [64];
  int            m_ptr, m_starve, m_rid, m_last_win;
  bit            m_pv, m_last_brdy;
  logic [DW-1:0] m_pdata;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] a_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] d_of(input int i);
    return req_wdata[i*DW +: DW];
  endfunction

  task automatic set_req(input int i, input bit en, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]                 = en;
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic set_b(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bwr_valid = v;
    bwr_addr  = a;
    bwr_data  = d;
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic cycle();
    int  win;
    bit  brdy;
    int  idx;
    #1;
    win = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (win < 0 && req[idx] &&
            !(m_starve >= 4 && bwr_valid && a_of(idx) == bwr_addr)) win = idx;
      end
    end
    brdy = !rst && bwr_valid &&
           !(win >= 0 && req_we[win] && a_of(win) == bwr_addr);

    chk("rvalid", 32'(rvalid), 32'(!rst && m_pv));
    chk("rid", 32'(rid), rst ? 32'd0 : 32'(m_rid));
    chk("rdata", 32'(rdata), (!rst && m_pv) ? 32'(m_pdata) : 32'd0);
    chk("gnt", 32'(gnt), (win >= 0) ? (32'd1 << win) : 32'd0);
    chk("ram_ena", 32'(ram_ena), 32'(win >= 0));
    chk("bwr_ready", 32'(bwr_ready), 32'(brdy));
    chk("ram_enb", 32'(ram_enb), 32'(brdy));
    if (win >= 0) begin
      chk("ram_wea", 32'(ram_wea), 32'(req_we[win]));
      chk("ram_addra", 32'(ram_addra), 32'(a_of(win)));
      if (req_we[win]) chk("ram_dia", 32'(ram_dia), 32'(d_of(win)));
    end
    if (brdy) begin
      chk("ram_addrb", 32'(ram_addrb), 32'(bwr_addr));
      chk("ram_dib", 32'(ram_dib), 32'(bwr_data));
    end

    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_starve = 0; m_pv = 1'b0; m_rid = 0;
    end else begin
      m_pv = (win >= 0) && !req_we[win];
      if (m_pv) begin
        m_rid   = win;
        m_pdata = (brdy && a_of(win) == bwr_addr) ? bwr_data : exp_mem[a_of(win)];
      end
      if (win >= 0 && req_we[win]) exp_mem[a_of(win)] = d_of(win);
      if (brdy) exp_mem[bwr_addr] = bwr_data;
      if (win >= 0) m_ptr = (win + 1) % N;
      if (bwr_valid && !brdy) m_starve = (m_starve < 7) ? m_starve + 1 : 7;
      else if (brdy) m_starve = 0;
    end
    m_last_win  = win;
    m_last_brdy = brdy;
    @(negedge clk);
  endtask

  // Random stimulus state
  bit            p_act [N];
  bit            p_we  [N];
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_data [N];
  bit            b_act;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;

  initial begin
    int ord [5];
    ord = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 64; i++) exp_mem[i] = init_val(i);
    m_ptr = 0; m_starve = 0; m_pv = 1'b0; m_rid = 0; m_pdata = '0;
    rst = 1'b1; preload = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    set_b(1'b0, '0, '0);

    // Reset, then idle
    @(negedge clk);
    cycle();
    preload = 1'b0;
    cycle();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) cycle();

    // All four read their own index: grants rotate 0,1,2,3,0
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(i), '0);
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_order", 32'(gnt), 32'd1 << ord[k]);
      cycle();
    end
    req = '0;
    cycle();

    // A write vs B write, same address: A wins, B retries
    set_req(2, 1'b1, 1'b1, 6'h05, 16'hBEEF);
    set_b(1'b1, 6'h05, 16'h1234);
    #1 chk("ww_block", 32'(bwr_ready), 32'd0);
    cycle();
    req = '0;
    #1 chk("ww_retry", 32'(bwr_ready), 32'd1);
    cycle();
    set_b(1'b0, '0, '0);
    set_req(0, 1'b1, 1'b0, 6'h05, '0);
    cycle();
    req = '0;
    #1 chk("ww_final", 32'(rdata), 32'h1234);
    cycle();

    // A read vs B write, same address: read sees B's data
    set_b(1'b1, 6'h0A, 16'h1111);
    cycle();
    set_req(0, 1'b1, 1'b0, 6'h0A, '0);
    set_b(1'b1, 6'h0A, 16'h2222);
    cycle();
    req = '0;
    set_b(1'b0, '0, '0);
    #1 chk("rw_byp_data", 32'(rdata), 32'h2222);
    chk("rw_byp_rid", 32'(rid), 32'd0);
    cycle();

    // Starvation guard: B blocked 4 cycles, accepted on the 5th
    set_req(1, 1'b1, 1'b1, 6'h3F, 16'h0F0F);
    set_b(1'b1, 6'h3F, 16'h7777);
    for (int k = 0; k < 5; k++) begin
      #1 chk("starve_bready", 32'(bwr_ready), (k == 4) ? 32'd1 : 32'd0);
      chk("starve_gnt1", 32'(gnt[1]), (k == 4) ? 32'd0 : 32'd1);
      cycle();
    end
    req = '0;
    set_b(1'b0, '0, '0);
    cycle();

    // Reset right after a read grant drops the response and the pointer
    set_req(0, 1'b1, 1'b0, 6'h01, '0);
    cycle();
    rst = 1'b1;
    #1 chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    cycle();
    rst = 1'b0;
    req = '0;
    #1 chk("rst_no_resp", 32'(rvalid), 32'd0);
    cycle();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(i), '0);
    #1 chk("rst_ptr0", 32'(gnt), 32'd1);
    cycle();
    req = '0;
    cycle();

    // Randomized traffic concentrated on a few addresses
    for (int i = 0; i < N; i++) p_act[i] = 1'b0;
    b_act = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!p_act[i] && ($urandom % 3 == 0)) begin
          p_act[i]  = 1'b1;
          p_we[i]   = ($urandom % 2) == 1;
          p_addr[i] = ($urandom % 16 == 0) ? 6'h3F : AW'($urandom % 8);
          p_data[i] = DW'($urandom);
        end
        set_req(i, p_act[i], p_we[i], p_addr[i], p_data[i]);
      end
      if (!b_act && ($urandom % 2 == 0)) begin
        b_act  = 1'b1;
        b_addr = ($urandom % 16 == 0) ? 6'h3F : AW'($urandom % 8);
        b_data = DW'($urandom);
      end
      set_b(b_act, b_addr, b_data);
      rst = ($urandom % 300 == 0);
      cycle();
      if (m_last_win >= 0) p_act[m_last_win] = 1'b0;
      if (m_last_brdy) b_act = 1'b0;
    end
    rst = 1'b0;
    req = '0;
    set_b(1'b0, '0, '0);
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dp_ram_port_arbiter.md
Name: dp_ram_port_arbiter

Overview:
- Single-clock controller that shares the read/write port (port A) of a 1RW+1W dual-port RAM (64x16 default) among N requesters.
- Uses round-robin arbitration.
- Also sequences a single write-only client onto port B.
- Resolves same-address collisions between the ports and returns read data with a fixed one-cycle latency.
- Sits between client engines and the RAM macro; both RAM clocks are tied to clk.

Parameters:
- N, 4, number of port-A requesters (2..8).
- AW, 6, address width.
- DW, 16, data width.

Ports:
- clk  in  1  single clock; also drives both RAM clocks.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester access request.
- req_we  in  N  per-requester write flag (1 = write, 0 = read).
- req_addr  in  N*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  in  N*DW  packed write data.
- gnt  out  N  one-hot grant; the access is accepted this cycle.
- rvalid  out  1  read data valid.
- rid  out  $clog2(N)  requester index owning rdata.
- rdata  out  DW  read data.
- bwr_valid  in  1  port-B write request.
- bwr_addr  in  AW  port-B write address.
- bwr_data  in  DW  port-B write data.
- bwr_ready  out  1  port-B write accepted this cycle.
- ram_ena, ram_wea  out  1 each  RAM port-A enable and write enable.
- ram_addra  out  AW  RAM port-A address.
- ram_dia  out  DW  RAM port-A write data.
- ram_doa  in  DW  RAM port-A registered read data (read-first).
- ram_enb  out  1  RAM port-B write enable.
- ram_addrb  out  AW  RAM port-B address.
- ram_dib  out  DW  RAM port-B write data.

Behaviour:
- Reset (synchronous, active-high):
  - Round-robin pointer = 0.
  - rvalid = 0, rid = 0, rdata = 0.
  - Bypass flag = 0.
  - Combinational outputs resolve to idle: gnt = 0, ram_ena = 0, ram_enb = 0, bwr_ready = 0.
- Arbitration (combinational, each cycle):
  - Search starts at the pointer and wraps N-1 -> 0; the first asserted req wins.
  - gnt is one-hot or zero.
  - ram_ena = |gnt; ram_wea/ram_addra/ram_dia are muxed from the winner.
- Pointer update:
  - On any grant, pointer <= winner+1, wrapping at N.
  - With no grant the pointer holds.
  - A continuously requesting client therefore waits at most N-1 cycles.
- Handshake:
  - gnt[i] is only ever asserted when req[i]=1.
  - A requester holds req, addr, we and wdata stable until it is granted.
  - The grant cycle is the transfer cycle; there is no separate acknowledge.
- Read latency:
  - A read granted in cycle t gives rvalid=1 in cycle t+1, with rid = winner and rdata = ram_doa.
  - Writes never raise rvalid.
- Port B, no collision: bwr_ready = bwr_valid; ram_enb = bwr_valid; address and data pass straight through.
- Collision, A write and B write to the same address in the same cycle:
  - Port A proceeds.
  - bwr_ready = 0 and ram_enb = 0; B retries next cycle.
- Collision, A read and B write to the same address in the same cycle:
  - Both proceed.
  - The RAM returns the old data, so the controller registers bwr_data and a bypass flag.
  - In cycle t+1, rdata = the captured bwr_data instead of ram_doa.
- Port-B starvation guard:
  - If B has been blocked 4 consecutive cycles, the next cycle masks all port-A grants to that address.
  - Port-A requests to other addresses proceed.
  - B is then accepted and the counter clears.
  - Counter width is 3 bits; it resets to 0.
- Idle: no req and no bwr_valid -> all enables 0; pointer and counters hold.
- Reset asserted mid-read: the pending rvalid is dropped and no response is issued for an access granted in the reset cycle.

Decomposition:
- Package dp_ram_arb_pkg holds:
  - constant STARVE_LIMIT = 4;
  - function to extract a packed slice;
  - localparam-style IDW = $clog2(N) helper.
- One sub-module: rr_arbiter. Inputs: req vector and pointer. Outputs: one-hot gnt and binary index. Purely combinational.
- The collision, bypass and latency logic stays in the top level.

Test Plan:
- Reset, then req=0, bwr_valid=0 -> all enables 0, rvalid stays 0 for 10 cycles, pointer = 0.
- req=4'b1111, all reads, addr=i -> grant order 0,1,2,3,0; rvalid one cycle after each grant with rid matching and rdata = mem[i].
- Requester 2 writes 0xBEEF to 0x05 while B writes 0x1234 to 0x05 -> bwr_ready=0 that cycle; B is accepted next cycle; final mem[0x05] = 0x1234.
- mem[0x0A] = 0x1111; requester 0 reads 0x0A while B writes 0x2222 to 0x0A -> next cycle rdata = 0x2222, rid = 0.
- Requester 1 writes continuously to 0x3F while B writes to 0x3F -> B is blocked 4 cycles, accepted on the 5th, and requester 1 receives no gnt in that cycle.
- Read granted, then rst=1 on the next cycle -> rvalid = 0 and the pointer returns to 0.
